fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: instruction-fetch stage feeding the decoder.
// Owns the PC and issues word requests over req/gnt + rvalid. Returned words are
// buffered in an in-order FIFO and handed to the decoder with valid/ready. A
// redirect from execute flushes the buffer, drains in-flight fetches and restarts
// at the target.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect -> fault + HALT).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetchStateT;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } fetchEntryT;

  fetchStateT       state;
  logic [31:0]      pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic             fetchEn;
  logic             faultR;

  fetchEntryT       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;

  logic             grant;
  logic             pop;
  logic             push;
  logic             creditOk;
  logic [CNT_W-1:0] outNext;
  logic [31:0]      respPc;
  logic [31:0]      redirTarget;
  logic             misaligned;
  logic             faultNext;
  fetchEntryT       pushEntry;

  // Redirect target handling: fault on misalignment, or silently word-align
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirTarget = redirect_pc;
  assign fetch_fault = faultR;
`else
  logic unusedRedirLsb;
  assign unusedRedirLsb = ^redirect_pc[1:0];
  assign misaligned     = 1'b0;
  assign redirTarget    = {redirect_pc[31:2], 2'b00};
  assign fetch_fault    = 1'b0;
`endif

  // Request/credit, response bookkeeping and decoder-side handshake
  always_comb begin
    creditOk  = (SUM_W'({1'b0, outstanding}) + SUM_W'({1'b0, count})) < SUM_W'(FIFO_DEPTH);
    imem_req  = fetchEn && (state == FETCH) && creditOk && !redirect_valid;
    imem_addr = pc;
    grant     = imem_req && imem_gnt;
    inst_valid = (count != '0);
    pop       = inst_valid && inst_ready;
    // Responses only land in the FIFO when nothing is being discarded and no flush is underway
    push      = imem_rvalid && (state == FETCH) && (discard == '0) && !redirect_valid;
    outNext   = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
    // Live requests since the last redirect are sequential, so the oldest one is pc - 4*outstanding
    respPc    = pc - (32'(outstanding) << 2);
    faultNext = redirect_valid ? misaligned : faultR;
    pushEntry.word = imem_rdata;
    pushEntry.addr = respPc;
    if (inst_valid) begin
      inst    = fifoMem[rdPtr].word;
      inst_pc = fifoMem[rdPtr].addr;
    end else begin
      inst    = NOP;
      inst_pc = 32'h0000_0000;
    end
  end

  // PC, in-flight/discard counters and FETCH/DRAIN/HALT state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fetchEn     <= 1'b0;
      faultR      <= 1'b0;
    end else begin
      fetchEn     <= 1'b1;
      outstanding <= outNext;
      if (redirect_valid) begin
        pc     <= redirTarget;
        faultR <= misaligned;
      end else if (grant) begin
        pc <= pc + 32'd4;
      end
      unique case (state)
        FETCH: begin
          if (redirect_valid) begin
            // Everything still in flight after this edge must be thrown away
            discard <= outNext;
            if (outNext != '0) begin
              state <= DRAIN;
            end else if (misaligned) begin
              state <= HALT;
            end
          end
        end
        DRAIN: begin
          if (imem_rvalid && (discard != '0)) begin
            discard <= discard - CNT_W'(1);
          end
          if (discard == '0) begin
            state <= faultNext ? HALT : FETCH;
          end
        end
        HALT: begin
          if (redirect_valid && !misaligned) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage, written on accepted responses
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= pushEntry;
    end
  end

  // The credit rule must keep the buffer from ever overflowing
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && (count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: scoreboard bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } respT;

  respT        respQ[$];
  logic [31:0] expQ[$];

  int          nCompared = 0;
  int          nMismatched = 0;
  int          cycle = 0;
  int          memLat = 1;
  int          firstGrantCycle = -1;
  int          firstValidCycle = -1;
  logic        gntCtl = 1'b0;
  logic        readyCtl = 1'b0;
  logic        redirCtl = 1'b0;
  logic [31:0] redirPcCtl = 32'h0;
  logic        armValid = 1'b0;
  logic [31:0] armPc = 32'h0;
  logic [31:0] armTarget = 32'h0;
  logic [31:0] modelPc = 32'h0;
  logic        holdPending = 1'b0;
  logic [31:0] holdAddr = 32'h0;
  logic        watchFirstPop = 1'b0;
  logic [31:0] firstPopPc = 32'h0;
  logic [31:0] popAtRedirPc = 32'hFFFF_FFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Observe the handshakes that will complete at the coming edge and update the model
  task automatic sample();
    logic        grant;
    logic        pop;
    logic [31:0] e;
    grant = imem_req && imem_gnt;
    pop   = inst_valid && inst_ready;
    if (holdPending && !redirect_valid) begin
      checkVal("req_hold", 32'(imem_req), 32'd1);
      checkVal("addr_hold", imem_addr, holdAddr);
    end
    holdPending = imem_req && !imem_gnt;
    holdAddr    = imem_addr;
    if (inst_valid && firstValidCycle < 0) firstValidCycle = cycle;
    if (pop) begin
      if (expQ.size() == 0) begin
        checkVal("pop_with_nothing_expected", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkVal("inst_pc", inst_pc, e);
        checkVal("inst_word", inst, memData(e));
        if (watchFirstPop) begin
          firstPopPc    = inst_pc;
          watchFirstPop = 1'b0;
        end
        if (redirect_valid) popAtRedirPc = inst_pc;
      end
    end
    if (grant) begin
      checkVal("fetch_addr", imem_addr, modelPc);
      respQ.push_back('{addr: imem_addr, due: cycle + memLat});
      if (firstGrantCycle < 0) firstGrantCycle = cycle;
    end
    if (redirect_valid) begin
      expQ.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      modelPc = redirect_pc;
`else
      modelPc = redirect_pc & 32'hFFFF_FFFC;
`endif
      watchFirstPop = 1'b1;
    end else if (grant) begin
      expQ.push_back(modelPc);
      modelPc = modelPc + 32'd4;
    end
    if (expQ.size() > DEPTH) checkVal("credit_limit", 32'(expQ.size()), DEPTH);
  endtask

  // One clock: drive inputs just after the edge, sample at the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    imem_gnt       = gntCtl;
    inst_ready     = readyCtl;
    redirect_valid = redirCtl;
    redirect_pc    = redirPcCtl;
    redirCtl       = 1'b0;
    if (armValid && inst_valid && inst_pc == armPc) begin
      redirect_valid = 1'b1;
      redirect_pc    = armTarget;
      armValid       = 1'b0;
    end
    if (respQ.size() > 0 && respQ[0].due <= cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memData(respQ[0].addr);
      void'(respQ.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    sample();
  endtask

  task automatic redirectTo(input logic [31:0] target);
    redirCtl   = 1'b1;
    redirPcCtl = target;
    step();
  endtask

  task automatic runUntilFirstPop(input int maxCycles, input string tag, input logic [31:0] expPc);
    for (int i = 0; i < maxCycles && watchFirstPop; i++) step();
    if (watchFirstPop) checkVal({tag, "_timeout"}, 32'(watchFirstPop), 32'd0);
    else checkVal(tag, firstPopPc, expPc);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(negedge clk);
    checkVal("rst_imem_req", 32'(imem_req), 32'd0);
    checkVal("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkVal("rst_inst_nop", inst, 32'h0000_0013);
    checkVal("rst_inst_pc", inst_pc, 32'h0);
    checkVal("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    checkVal("rst_imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming: always granted, 1-cycle memory, decoder always ready
    gntCtl   = 1'b1;
    readyCtl = 1'b1;
    repeat (12) step();
    checkVal("first_grant_to_valid", 32'(firstValidCycle - firstGrantCycle), 32'd2);

    // Decoder stall: requests stop at the buffer limit, head stays put
    readyCtl = 1'b0;
    repeat (10) step();
    checkVal("stall_inflight_plus_buffered", 32'(expQ.size()), DEPTH);
    checkVal("stall_no_req", 32'(imem_req), 32'd0);
    checkVal("stall_head_pc", inst_pc, expQ[0]);
    readyCtl = 1'b1;
    repeat (8) step();

    // Grant withheld: request and address held until granted
    gntCtl = 1'b0;
    for (int i = 0; i < 10 && expQ.size() != 0; i++) step();
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("gnt_wait_req", 32'(imem_req), 32'd1);
      checkVal("gnt_wait_addr", imem_addr, modelPc);
    end
    gntCtl = 1'b1;
    repeat (6) step();

    // Redirect with two fetches in flight (slow memory)
    memLat = 3;
    for (int i = 0; i < 10 && respQ.size() < 2; i++) step();
    checkVal("inflight_before_redirect", 32'(respQ.size()), 32'd2);
    memLat = 1;
    redirectTo(32'h0000_0100);
    step();
    checkVal("drain_no_req", 32'(imem_req), 32'd0);
    runUntilFirstPop(30, "post_redirect_pc", 32'h0000_0100);
    repeat (4) step();

    // Redirect coincident with the pop of 0x4
    redirectTo(32'h0000_0000);
    armPc     = 32'h0000_0004;
    armTarget = 32'h0000_0300;
    armValid  = 1'b1;
    runUntilFirstPop(30, "restart_pc", 32'h0000_0000);
    for (int i = 0; i < 20 && armValid; i++) step();
    checkVal("coincident_redirect_fired", 32'(armValid), 32'd0);
    checkVal("coincident_pop_pc", popAtRedirPc, 32'h0000_0004);
    runUntilFirstPop(30, "coincident_post_pc", 32'h0000_0300);
    repeat (4) step();

    // Misaligned redirect
    redirectTo(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (8) step();
    checkVal("fault_set", 32'(fetch_fault), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("halt_no_req", 32'(imem_req), 32'd0);
    end
    redirectTo(32'h0000_0200);
    checkVal("fault_cleared", 32'(fetch_fault), 32'd0);
    runUntilFirstPop(30, "after_fault_pc", 32'h0000_0200);
`else
    checkVal("fault_tied_low", 32'(fetch_fault), 32'd0);
    runUntilFirstPop(30, "aligned_target_pc", 32'h0000_0100);
    repeat (3) step();
    redirectTo(32'h0000_0200);
    runUntilFirstPop(30, "second_target_pc", 32'h0000_0200);
`endif

    // Let everything outstanding retire
    gntCtl = 1'b0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
    checkVal("final_drain", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cycle);
    $fatal(1, "watchdog expired");
  end

endmodule
